aes_inv_cipher_seq: RTL and testbench
=====================================

// Module: aes_inv_cipher_seq
// PURPOSE
//  Iterative AES inverse-cipher sequencer: accepts one 128-bit ciphertext block, runs the
//  FIPS-197 InvCipher one round per clock over a shared combinational round datapath
//  (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns), and returns the plaintext.
//  Sits between the block-level valid/ready stream and the round-key store, which it indexes.
// PARAMETERS
//  NR     10  number of rounds (10/12/14 for AES-128/192/256); legal values only, else elaboration error
//  RK_W   4   width of round-key index; must satisfy 2**RK_W > NR
// PORTS
//  clk       in   1      rising-edge clock; the only clock
//  rst_n     in   1      synchronous active-low reset
//  in_valid  in   1      ciphertext block offered
//  in_ready  out  1      block accepted when in_valid & in_ready
//  data_in   in   128    ciphertext, bit order [0:127], byte 0 = bits [0:7], column-major state
//  abort     in   1      synchronous flush of any block in flight
//  rk_idx    out  RK_W   round-key index requested this cycle
//  rk_data   in   128    round key for rk_idx, combinational, same cycle, [0:127] order
//  out_valid out  1      plaintext available
//  out_ready in   1      plaintext consumed when out_valid & out_ready
//  data_out  out  128    plaintext, [0:127] order; stable while out_valid
//  busy      out  1      high in any state except IDLE
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state IDLE, round counter 0, state register 0; outputs
//    in_ready=1, out_valid=0, busy=0, data_out=0, rk_idx=NR.
//  - FSM states: IDLE, ROUND, FINAL, DONE.
//  - IDLE: in_ready=1, rk_idx=NR. On accept: st <= data_in ^ rk_data; rnd <= NR-1; -> ROUND.
//  - ROUND: rk_idx=rnd. st <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(st)), rk_data));
//    rnd <= rnd-1; when rnd==1 -> FINAL (rnd becomes 0). Runs NR-1 cycles.
//  - FINAL: rk_idx=0. st <= AddRoundKey(InvSubBytes(InvShiftRows(st)), rk_data) (no InvMixColumns);
//    -> DONE.
//  - DONE: out_valid=1, data_out=st. Hold until out_ready; on handshake -> IDLE (out_valid=0
//    next cycle). in_ready=0 in DONE, so a new block is accepted one cycle after output taken.
//  - Latency: accept at cycle T -> out_valid high from cycle T+NR+1 (T+11 for NR=10).
//    Throughput with out_ready tied high: one block per NR+2 cycles.
//  - in_ready is high only in IDLE; in_valid outside IDLE is ignored, data_in not sampled.
//  - rk_idx is a pure function of state/rnd (registered values), never of inputs.
//  - abort: in any state -> IDLE next cycle, out_valid=0, st cleared; abort overrides
//    a same-cycle input accept (block dropped) and a same-cycle output handshake.
//  - rst_n low mid-operation: identical to reset values next cycle; no partial output.
//  - Round counter never underflows: FINAL is entered with rnd=0 and rnd is not decremented there.
//  - data_out is registered; no combinational path from any input to any output except none
//    (in_ready, out_valid, busy, rk_idx all derived from registers).
// STRUCTURE
//  - aes_pkg: typedef logic [0:127] aes_block_t; enum aes_inv_state_t {IDLE,ROUND,FINAL,DONE};
//    localparams NR_AES128=10, NR_AES192=12, NR_AES256=14.
//  - Sub-module aes_inv_round (combinational): in st, rk, last -> InvShiftRows, InvSubBytes,
//    AddRoundKey, InvMixColumns bypassed when last=1; instantiates the existing inv_shift_rows,
//    inv_sub_bytes and inv_mix_columns blocks. Sequencer holds FSM, counter, state register.
// TESTING
//  - FIPS-197 C.1: ct 69c4e0d86a7b0430d8cdb78070b4c55a, key 000102..0f schedule in model store
//    -> data_out 00112233445566778899aabbccddeeff, out_valid exactly 11 cycles after accept.
//  - rk_idx trace for that block: 10 (accept), 9,8,...,1, 0, then 10 in IDLE; store must see no other index.
//  - Backpressure: out_ready low 5 cycles in DONE -> out_valid and data_out stable, in_ready=0,
//    in_valid pulses ignored; out_ready high -> IDLE, next block accepted following cycle.
//  - Back-to-back 3 random blocks, out_ready=1 -> results match reference model, 12-cycle spacing.
//  - abort asserted in ROUND rnd=5, and separately same cycle as accept -> IDLE next cycle,
//    no out_valid, following block decrypts correctly.
//  - rst_n pulsed low in FINAL and in DONE -> all outputs at reset values next cycle; NR=14
//    with AES-256 C.3 vector -> 00112233..eeff after 15 cycles.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES types, round-count constants and GF(2^8) helpers for the inverse-cipher datapath.
package aes_pkg;

    localparam int unsigned BLK_W     = 128;
    localparam int unsigned NB_BYTES  = BLK_W / 8;
    localparam int unsigned NR_AES128 = 10;
    localparam int unsigned NR_AES192 = 12;
    localparam int unsigned NR_AES256 = 14;

    // Byte 0 lives in bits [0:7]; the state is column-major (byte r+4c = row r, column c).
    typedef logic [0:BLK_W-1] aes_block_t;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        FINAL,
        DONE
    } aes_inv_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; zero maps to zero as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    // Inverse S-box: undo the affine transform, then invert in GF(2^8).
    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] b;
        b = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One InvCipher round; the last round skips InvMixColumns.
module aes_inv_round
    import aes_pkg::*;
(
    input  aes_block_t st,
    input  aes_block_t rk,
    input  logic       last,
    output aes_block_t res
);

    aes_block_t shifted;
    aes_block_t subbed;
    aes_block_t keyed;
    aes_block_t mixed;

    inv_shift_rows u_shift (.st(st),     .res(shifted));
    inv_sub_bytes  u_sub   (.st(shifted), .res(subbed));

    assign keyed = subbed ^ rk;

    inv_mix_columns u_mix (.st(keyed), .res(mixed));

    assign res = last ? keyed : mixed;

endmodule

// File: rtl/inv_mix_columns.sv
// InvMixColumns: each column multiplied by the circulant {0e,0b,0d,09} matrix.
module inv_mix_columns
    import aes_pkg::*;
(
    input  aes_block_t st,
    output aes_block_t res
);

    localparam logic [7:0] COEF [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};

    always_comb begin : mix
        logic [7:0] acc;
        res = '0;
        acc = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = '0;
                for (int k = 0; k < 4; k++) begin
                    acc = acc ^ gf_mul(COEF[(k + 4 - r) % 4], st[8 * (k + 4 * c) +: 8]);
                end
                res[8 * (r + 4 * c) +: 8] = acc;
            end
        end
    end

endmodule

// File: rtl/inv_shift_rows.sv
// InvShiftRows: row r of the state rotates right by r columns.
module inv_shift_rows
    import aes_pkg::*;
(
    input  aes_block_t st,
    output aes_block_t res
);

    always_comb begin
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                res[8 * (r + 4 * c) +: 8] = st[8 * (r + 4 * ((c + 4 - r) % 4)) +: 8];
            end
        end
    end

endmodule

// File: rtl/inv_sub_bytes.sv
// InvSubBytes: inverse S-box applied to every state byte.
module inv_sub_bytes
    import aes_pkg::*;
(
    input  aes_block_t st,
    output aes_block_t res
);

    always_comb begin
        res = '0;
        for (int i = 0; i < int'(NB_BYTES); i++) begin
            res[8 * i +: 8] = inv_sbox(st[8 * i +: 8]);
        end
    end

endmodule

// File: rtl/aes_inv_cipher_seq.sv
// Iterative AES inverse cipher: one round per clock over a shared round datapath,
// valid/ready block ports, round keys fetched from an external store by index.
module aes_inv_cipher_seq
    import aes_pkg::*;
#(
    parameter int unsigned NR   = 10,
    parameter int unsigned RK_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  aes_block_t      data_in,
    input  logic            abort,
    output logic [RK_W-1:0] rk_idx,
    input  aes_block_t      rk_data,
    output logic            out_valid,
    input  logic            out_ready,
    output aes_block_t      data_out,
    output logic            busy
);

    if (!(NR == NR_AES128 || NR == NR_AES192 || NR == NR_AES256) || (2 ** RK_W) <= NR) begin : g_bad_param
        $error("aes_inv_cipher_seq: NR must be 10/12/14 and 2**RK_W must exceed NR");
    end

    aes_inv_state_t  state;
    aes_inv_state_t  state_nxt;
    logic [RK_W-1:0] rnd;
    logic [RK_W-1:0] rnd_nxt;
    aes_block_t      st;
    aes_block_t      st_nxt;
    aes_block_t      round_res;
    logic            last;

    aes_inv_round u_round (
        .st   (st),
        .rk   (rk_data),
        .last (last),
        .res  (round_res)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            rnd   <= '0;
            st    <= '0;
        end else begin
            state <= state_nxt;
            rnd   <= rnd_nxt;
            st    <= st_nxt;
        end
    end

    // rk_idx depends only on registered state so the key store sees no input-to-output path.
    always_comb begin
        state_nxt = state;
        rnd_nxt   = rnd;
        st_nxt    = st;
        rk_idx    = RK_W'(NR);
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    st_nxt    = data_in ^ rk_data;
                    rnd_nxt   = RK_W'(NR - 1);
                    state_nxt = ROUND;
                end
            end
            ROUND: begin
                rk_idx  = rnd;
                st_nxt  = round_res;
                rnd_nxt = rnd - RK_W'(1);
                if (rnd == RK_W'(1)) state_nxt = FINAL;
            end
            FINAL: begin
                rk_idx    = '0;
                last      = 1'b1;
                st_nxt    = round_res;
                state_nxt = DONE;
            end
            DONE: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Flush wins over any same-cycle accept or output handshake.
        if (abort) begin
            state_nxt = IDLE;
            rnd_nxt   = '0;
            st_nxt    = '0;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign data_out  = st;

endmodule

// File: tb/tb_aes_inv_cipher_seq.sv
// Bench for aes_inv_cipher_seq: known-answer and random blocks checked against a forward-cipher
// model (decrypt(encrypt(p)) == p), plus backpressure, abort, reset and AES-256 sequences.
module tb_aes_inv_cipher_seq;

    typedef logic [0:127] blk_t;
    typedef struct {
        logic [0:127] key;
        blk_t         ct;
        blk_t         pt;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       in_valid, in_ready, abort, out_valid, out_ready, busy;
    blk_t       data_in, rk_data, data_out;
    logic [3:0] rk_idx;

    logic       in_valid2, in_ready2, abort2, out_valid2, out_ready2, busy2;
    blk_t       data_in2, rk_data2, data_out2;
    logic [3:0] rk_idx2;

    blk_t       rk128 [16];
    blk_t       rk256 [16];
    logic [7:0] sbox [256];

    int n_vec;
    int n_err;

    assign rk_data  = rk128[rk_idx];
    assign rk_data2 = rk256[rk_idx2];

    aes_inv_cipher_seq #(.NR(10), .RK_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
        .abort(abort), .rk_idx(rk_idx), .rk_data(rk_data), .out_valid(out_valid),
        .out_ready(out_ready), .data_out(data_out), .busy(busy)
    );

    aes_inv_cipher_seq #(.NR(14), .RK_W(4)) dut256 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2), .data_in(data_in2),
        .abort(abort2), .rk_idx(rk_idx2), .rk_data(rk_data2), .out_valid(out_valid2),
        .out_ready(out_ready2), .data_out(data_out2), .busy(busy2)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model: forward AES from first principles ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox[x] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] t);
        return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
    endfunction

    task automatic expand_key(input logic [0:255] key, input bit big);
        logic [31:0] w [60];
        logic [31:0] tmp;
        logic [7:0]  rcon;
        int nk;
        int nr;
        nk   = big ? 8 : 4;
        nr   = nk + 6;
        rcon = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[32 * i +: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            tmp = w[i - 1];
            if (i % nk == 0) begin
                tmp  = sub_word({tmp[23:0], tmp[31:24]}) ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end else if (nk > 6 && i % nk == 4) begin
                tmp = sub_word(tmp);
            end
            w[i] = w[i - nk] ^ tmp;
        end
        for (int r = 0; r <= nr; r++) begin
            if (big) rk256[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
            else     rk128[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
        end
    endtask

    function automatic blk_t encrypt(input blk_t p, input bit big);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        blk_t k;
        blk_t res;
        int nr;
        nr = big ? 14 : 10;
        k  = big ? rk256[0] : rk128[0];
        for (int i = 0; i < 16; i++) s[i] = p[8 * i +: 8] ^ k[8 * i +: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++)
                    t[w + 4 * c] = sbox[s[w + 4 * ((c + w) % 4)]];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4 * c]; a1 = t[4 * c + 1]; a2 = t[4 * c + 2]; a3 = t[4 * c + 3];
                if (r != nr) begin
                    s[4 * c]     = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4 * c + 1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4 * c + 2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4 * c + 3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end else begin
                    s[4 * c] = a0; s[4 * c + 1] = a1; s[4 * c + 2] = a2; s[4 * c + 3] = a3;
                end
            end
            k = big ? rk256[r] : rk128[r];
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[8 * i +: 8];
        end
        for (int i = 0; i < 16; i++) res[8 * i +: 8] = s[i];
        return res;
    endfunction

    function automatic blk_t rnd_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- sequences ----------------
    task automatic chk_reset(input string name);
        chk({name, " in_ready"},  128'(in_ready),  128'd1);
        chk({name, " out_valid"}, 128'(out_valid), 128'd0);
        chk({name, " busy"},      128'(busy),      128'd0);
        chk({name, " data_out"},  data_out,        128'd0);
        chk({name, " rk_idx"},    128'(rk_idx),    128'd10);
    endtask

    // Called one step after a clock edge with the DUT idle; returns with the DUT idle again.
    task automatic send_and_check(input blk_t ct, input blk_t pt, input string name);
        int lat;
        chk({name, " in_ready"},     128'(in_ready), 128'd1);
        chk({name, " accept rk_idx"}, 128'(rk_idx),  128'd10);
        in_valid  = 1'b1;
        data_in   = ct;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        data_in  = rnd_blk();
        chk({name, " busy"}, 128'(busy), 128'd1);
        lat = 1;
        while (!out_valid && lat < 40) begin
            chk({name, " rk_idx"}, 128'(rk_idx), (lat < 10) ? 128'(10 - lat) : 128'd0);
            @(posedge clk); #1;
            lat++;
        end
        chk({name, " latency"}, 128'(lat), 128'd11);
        chk({name, " data_out"}, data_out, pt);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({name, " out_valid after take"}, 128'(out_valid), 128'd0);
        chk({name, " idle rk_idx"},          128'(rk_idx),    128'd10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t  vecs [5];
        vec_t  v256 [2];
        blk_t  bct [3];
        blk_t  bpt [3];
        int    acc_c [3];
        int    out_c [3];
        int    ki, ko, cnt, lat;
        bit    fire, seen;
        blk_t  p, c;
        logic [0:127] k;
        logic [0:255] k256;
        logic [0:127] key_c1;

        n_vec = 0;
        n_err = 0;
        key_c1 = 128'h000102030405060708090a0b0c0d0e0f;
        build_sbox();
        rst_n = 1'b0; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0; data_in = '0;
        in_valid2 = 1'b0; abort2 = 1'b0; out_ready2 = 1'b1; data_in2 = '0;
        expand_key({key_c1, 128'h0}, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        chk("reset rk_idx nr14", 128'(rk_idx2), 128'd14);
        rst_n = 1'b1;

        // Table: FIPS-197 C.1 plus random key/plaintext pairs encrypted by the model.
        vecs[0] = '{key: key_c1, ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                    pt: 128'h00112233445566778899aabbccddeeff};
        for (int i = 1; i < 5; i++) begin
            k = rnd_blk();
            expand_key({k, 128'h0}, 1'b0);
            p = rnd_blk();
            vecs[i] = '{key: k, ct: encrypt(p, 1'b0), pt: p};
        end
        for (int i = 0; i < 5; i++) begin
            expand_key({vecs[i].key, 128'h0}, 1'b0);
            send_and_check(vecs[i].ct, vecs[i].pt, $sformatf("vec%0d", i));
        end

        // Backpressure: hold DONE for 5 cycles with stray in_valid pulses.
        expand_key({key_c1, 128'h0}, 1'b0);
        in_valid = 1'b1; data_in = vecs[0].ct;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 40) begin @(posedge clk); #1; cnt++; end
        for (int i = 0; i < 5; i++) begin
            chk("bp out_valid", 128'(out_valid), 128'd1);
            chk("bp data_out",  data_out,        vecs[0].pt);
            chk("bp in_ready",  128'(in_ready),  128'd0);
            in_valid = (i % 2 == 0);
            data_in  = rnd_blk();
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("bp data_out held", data_out, vecs[0].pt);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp in_ready after take", 128'(in_ready), 128'd1);
        p = rnd_blk();
        send_and_check(encrypt(p, 1'b0), p, "bp next");

        // Back-to-back: three blocks with out_ready tied high.
        k = rnd_blk();
        expand_key({k, 128'h0}, 1'b0);
        for (int i = 0; i < 3; i++) begin
            bpt[i] = rnd_blk(); bct[i] = encrypt(bpt[i], 1'b0); acc_c[i] = 0; out_c[i] = 0;
        end
        ki = 0; ko = 0;
        out_ready = 1'b1; in_valid = 1'b1; data_in = bct[0];
        for (int cyc = 0; cyc < 100 && ko < 3; cyc++) begin
            if (out_valid) begin
                chk($sformatf("b2b data %0d", ko), data_out, bpt[ko]);
                out_c[ko] = cyc;
                ko++;
            end
            fire = in_valid && in_ready;
            @(posedge clk); #1;
            if (fire) begin
                acc_c[ki] = cyc;
                ki++;
                if (ki < 3) data_in = bct[ki];
                else in_valid = 1'b0;
            end
        end
        out_ready = 1'b0;
        chk("b2b outputs", 128'(ko), 128'd3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("b2b latency %0d", i), 128'(out_c[i] - acc_c[i]), 128'd11);
        for (int i = 0; i < 2; i++)
            chk($sformatf("b2b spacing %0d", i), 128'(acc_c[i + 1] - acc_c[i]), 128'd12);

        // Abort while rnd == 5.
        expand_key({key_c1, 128'h0}, 1'b0);
        in_valid = 1'b1; data_in = vecs[0].ct;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cnt = 0;
        while (rk_idx != 4'd5 && cnt < 20) begin @(posedge clk); #1; cnt++; end
        chk("abort rnd5 reached", 128'(cnt), 128'd4);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort in_ready", 128'(in_ready), 128'd1);
        chk("abort busy",     128'(busy),     128'd0);
        chk("abort data_out", data_out,       128'd0);
        seen = 1'b0;
        repeat (14) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        chk("abort no out_valid", 128'(seen), 128'd0);
        send_and_check(vecs[0].ct, vecs[0].pt, "after abort");

        // Abort in the same cycle as the accept drops the block.
        in_valid = 1'b1; abort = 1'b1; data_in = vecs[0].ct;
        @(posedge clk); #1;
        in_valid = 1'b0; abort = 1'b0;
        chk("abort@accept busy",     128'(busy),     128'd0);
        chk("abort@accept data_out", data_out,       128'd0);
        seen = 1'b0;
        repeat (14) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        chk("abort@accept no out_valid", 128'(seen), 128'd0);
        p = rnd_blk();
        send_and_check(encrypt(p, 1'b0), p, "after abort@accept");

        // Reset pulses in FINAL and in DONE.
        in_valid = 1'b1; data_in = vecs[0].ct;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cnt = 0;
        while (!(busy && rk_idx == 4'd0) && cnt < 20) begin @(posedge clk); #1; cnt++; end
        chk("final reached", 128'(cnt), 128'd9);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk_reset("rst in FINAL");
        in_valid = 1'b1; data_in = vecs[0].ct;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 20) begin @(posedge clk); #1; cnt++; end
        chk("done reached", 128'(cnt), 128'd10);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk_reset("rst in DONE");
        send_and_check(vecs[0].ct, vecs[0].pt, "after reset");

        // NR=14 instance: FIPS-197 C.3 and one random AES-256 pair.
        k256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        v256[0] = '{key: '0, ct: 128'h8ea2b7ca516745bfeafc49904b496089,
                    pt: 128'h00112233445566778899aabbccddeeff};
        for (int j = 0; j < 2; j++) begin
            if (j == 1) begin
                k256 = {rnd_blk(), rnd_blk()};
                p = rnd_blk();
                expand_key(k256, 1'b1);
                c = encrypt(p, 1'b1);
                v256[1] = '{key: '0, ct: c, pt: p};
            end
            expand_key(k256, 1'b1);
            chk($sformatf("aes256 %0d accept rk_idx", j), 128'(rk_idx2), 128'd14);
            in_valid2 = 1'b1; data_in2 = v256[j].ct;
            @(posedge clk); #1;
            in_valid2 = 1'b0;
            lat = 1;
            while (!out_valid2 && lat < 60) begin @(posedge clk); #1; lat++; end
            chk($sformatf("aes256 %0d latency", j), 128'(lat), 128'd15);
            chk($sformatf("aes256 %0d data_out", j), data_out2, v256[j].pt);
            @(posedge clk); #1;
            chk($sformatf("aes256 %0d idle", j), 128'(busy2), 128'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
